// File: rtl/demux_2.sv
// demux_2: registered 1-to-4 demultiplexer, steered by sel or a round-robin ptr.
// Ports: clk, rst_n (async low), in/in_valid, sel, auto -> out_0..3, out_valid, ptr, frame_done.
module demux_2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:WIDTH-1] in,
  input  logic             in_valid,
  input  logic [0:1]       sel,
  input  logic             auto,
  output logic [0:WIDTH-1] out_0,
  output logic [0:WIDTH-1] out_1,
  output logic [0:WIDTH-1] out_2,
  output logic [0:WIDTH-1] out_3,
  output logic [0:3]       out_valid,
  output logic [0:1]       ptr,
  output logic             frame_done
);

  logic [0:WIDTH-1] data_q [0:3];
  logic [0:WIDTH-1] data_d [0:3];
  logic [0:3]       vld_q, vld_d;
  logic [0:3]       mask_q, mask_d;
  logic [0:1]       ptr_q, ptr_d;
  logic             fd_q, fd_d;

  logic [0:1]       tgt;
  logic [0:3]       oh;
  logic [0:3]       seen;

  always_comb begin
    tgt = auto ? ptr_q : sel;
    oh = '0;
    oh[tgt] = 1'b1;
    seen = mask_q | oh;
  end

  always_comb begin
    data_d = data_q;
    vld_d  = '0;
    mask_d = mask_q;
    ptr_d  = ptr_q;
    fd_d   = 1'b0;
    if (in_valid) begin
      data_d[tgt] = in;
      vld_d = oh;
      if (auto)
        ptr_d = ptr_q + 2'd1;
      // completing write closes the frame and starts the next one empty
      if (&seen) begin
        fd_d   = 1'b1;
        mask_d = '0;
      end else begin
        mask_d = seen;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++)
        data_q[i] <= '0;
      vld_q  <= '0;
      mask_q <= '0;
      ptr_q  <= '0;
      fd_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++)
        data_q[i] <= data_d[i];
      vld_q  <= vld_d;
      mask_q <= mask_d;
      ptr_q  <= ptr_d;
      fd_q   <= fd_d;
    end
  end

  assign out_0      = data_q[0];
  assign out_1      = data_q[1];
  assign out_2      = data_q[2];
  assign out_3      = data_q[3];
  assign out_valid  = vld_q;
  assign ptr        = ptr_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_demux_2.sv
// tb_demux_2: directed stimulus with a behavioural model and per-cycle compare.
// Literal expectations pin the model at key points of each scenario.
module tb_demux_2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [0:7] in = '0;
  logic       in_valid = 1'b0;
  logic [0:1] sel = '0;
  logic       auto = 1'b0;
  logic [0:7] out_0, out_1, out_2, out_3;
  logic [0:3] out_valid;
  logic [0:1] ptr;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  demux_2 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid),
    .sel(sel), .auto(auto),
    .out_0(out_0), .out_1(out_1), .out_2(out_2), .out_3(out_3),
    .out_valid(out_valid), .ptr(ptr), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // model state
  int   m_out [4];
  int   m_ptr;
  bit   m_wr [4];
  int   m_vch;
  bit   m_fd;

  function automatic logic [0:3] vmask(int ch);
    logic [0:3] v;
    v = 4'b1000;
    if (ch < 0) return 4'b0000;
    return v >> ch;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_out[i] = 0;
        m_wr[i] = 0;
      end
      m_ptr = 0;
      m_vch = -1;
      m_fd = 0;
    end else begin
      int c;
      m_vch = -1;
      m_fd = 0;
      if (in_valid) begin
        c = auto ? m_ptr : int'(sel);
        m_out[c] = int'(in);
        m_vch = c;
        m_wr[c] = 1;
        if (m_wr[0] && m_wr[1] && m_wr[2] && m_wr[3]) begin
          m_fd = 1;
          for (int i = 0; i < 4; i++) m_wr[i] = 0;
        end
        if (auto) m_ptr = (m_ptr + 1) % 4;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_out0", 64'(out_0), 64'(m_out[0]));
      chk("m_out1", 64'(out_1), 64'(m_out[1]));
      chk("m_out2", 64'(out_2), 64'(m_out[2]));
      chk("m_out3", 64'(out_3), 64'(m_out[3]));
      chk("m_valid", 64'(out_valid), 64'(vmask(m_vch)));
      chk("m_ptr", 64'(ptr), 64'(m_ptr));
      chk("m_fd", 64'(frame_done), 64'(m_fd));
    end
  end

  task automatic put(input logic v, input logic [0:7] d,
                     input logic [0:1] s, input logic a);
    in_valid = v;
    in = d;
    sel = s;
    auto = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out0", 64'(out_0), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_ptr", 64'(ptr), 64'h0);
    chk("rst_fd", 64'(frame_done), 64'h0);
    rst_n = 1'b1;

    // manual steering
    put(1, 8'd0, 2'b00, 0);
    chk("man_v0", 64'(out_valid), 64'b1000);
    chk("man_fd0", 64'(frame_done), 64'h0);
    put(1, 8'd1, 2'b01, 0);
    chk("man_v1", 64'(out_valid), 64'b0100);
    put(1, 8'd2, 2'b10, 0);
    chk("man_v2", 64'(out_valid), 64'b0010);
    chk("man_fd2", 64'(frame_done), 64'h0);
    put(1, 8'd3, 2'b11, 0);
    chk("man_v3", 64'(out_valid), 64'b0001);
    chk("man_fd3", 64'(frame_done), 64'h1);
    chk("man_o1", 64'(out_1), 64'h1);
    chk("man_o3", 64'(out_3), 64'h3);
    chk("man_ptr", 64'(ptr), 64'h0);
    put(0, 8'hFF, 2'b11, 0);
    chk("man_fdoff", 64'(frame_done), 64'h0);

    // round-robin wrap
    do_reset();
    for (int i = 0; i < 6; i++) begin
      put(1, 8'hA0 + 8'(i), 2'b11, 1);
      if (i == 3) begin
        chk("rr_fd", 64'(frame_done), 64'h1);
        chk("rr_o0", 64'(out_0), 64'hA0);
        chk("rr_o3", 64'(out_3), 64'hA3);
      end
    end
    chk("rr_o0b", 64'(out_0), 64'hA4);
    chk("rr_o1b", 64'(out_1), 64'hA5);
    chk("rr_ptr", 64'(ptr), 64'h2);
    chk("rr_fd2", 64'(frame_done), 64'h0);

    // duplicate writes
    do_reset();
    put(1, 8'h11, 2'b00, 0);
    put(1, 8'h22, 2'b00, 0);
    put(1, 8'h33, 2'b00, 0);
    put(1, 8'h44, 2'b01, 0);
    put(1, 8'h55, 2'b10, 0);
    chk("dup_fd_early", 64'(frame_done), 64'h0);
    put(1, 8'h66, 2'b11, 0);
    chk("dup_fd", 64'(frame_done), 64'h1);
    chk("dup_o0", 64'(out_0), 64'h33);

    // gaps and hold
    do_reset();
    put(1, 8'h5A, 2'b00, 1);
    for (int i = 0; i < 3; i++) begin
      put(0, 8'h10 + 8'(i), 2'(i + 1), 1);
      chk("gap_o0", 64'(out_0), 64'h5A);
      chk("gap_ptr", 64'(ptr), 64'h1);
      chk("gap_v", 64'(out_valid), 64'h0);
    end

    // async reset mid-frame
    do_reset();
    put(1, 8'hC0, 2'b00, 0);
    put(1, 8'hC1, 2'b01, 0);
    in_valid = 1'b1;
    in = 8'hEE;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_o0", 64'(out_0), 64'h0);
    chk("ar_o1", 64'(out_1), 64'h0);
    chk("ar_v", 64'(out_valid), 64'h0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    put(1, 8'hD2, 2'b10, 0);
    put(1, 8'hD3, 2'b11, 0);
    chk("ar_fd_a", 64'(frame_done), 64'h0);
    put(1, 8'hD0, 2'b00, 0);
    chk("ar_fd_b", 64'(frame_done), 64'h0);
    put(1, 8'hD1, 2'b01, 0);
    chk("ar_fd", 64'(frame_done), 64'h1);

    // mode switch
    do_reset();
    put(1, 8'h10, 2'b11, 1);
    put(1, 8'h20, 2'b11, 1);
    chk("ms_ptr2", 64'(ptr), 64'h2);
    put(1, 8'h30, 2'b00, 0);
    chk("ms_o0", 64'(out_0), 64'h30);
    chk("ms_ptrh", 64'(ptr), 64'h2);
    put(1, 8'h40, 2'b00, 1);
    chk("ms_o2", 64'(out_2), 64'h40);
    chk("ms_v", 64'(out_valid), 64'b0010);
    chk("ms_ptr3", 64'(ptr), 64'h3);
    put(0, 8'h00, 2'b00, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
